// File: rtl/fc_round_engine_if.sv
// Handshake and datapath bundle between the round engine, its controller and
// the external combinational round function.
interface fc_round_engine_if;
  logic          start;
  logic [63:0]   pt;
  logic [127:0]  key;
  logic [63:0]   rf_in;
  logic [63:0]   rf_out;
  logic          last_round;
  logic          busy;
  logic          done;
  logic [63:0]   ct;

  modport master (
    output start, pt, key, rf_out,
    input  rf_in, last_round, busy, done, ct
  );

  modport slave (
    input  start, pt, key, rf_out,
    output rf_in, last_round, busy, done, ct
  );
endinterface

// File: rtl/fc_round_engine.sv
// Iterative 64-bit round engine: holds the cipher state, sequences NROUNDS
// keyed rounds around an external round function and emits a done pulse.
module fc_round_engine #(
  parameter int NROUNDS = 10,
  parameter int ROT     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  fc_round_engine_if.slave bus
);

  localparam int ROT_M = ROT % 64;

  typedef enum logic {IDLE, RUN} state_e;

  state_e       state_q, state_d;
  logic [63:0]  st_q;
  logic [3:0]   round_q;
  logic [63:0]  k0_q, k1_q;
  logic [63:0]  ct_q;
  logic         done_q;
  logic         busy;
  logic         final_rnd;
  logic [63:0]  rk;

  // Fixed one-step rotation; the schedule advances a half by ROT each use.
  function automatic logic [63:0] rotl_step(input logic [63:0] x);
    return (x << ROT_M) | (x >> (64 - ROT_M));
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = RUN;
      RUN:  if (final_rnd) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q == RUN);
    final_rnd = busy && (round_q == 4'(NROUNDS));
  end

  // Odd rounds draw from the K1 half, even rounds from the K0 half.
  assign rk = (round_q[0] ? k1_q : k0_q) ^ {60'h0, round_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q    <= '0;
      round_q <= '0;
      k0_q    <= '0;
      k1_q    <= '0;
      ct_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy) begin
        if (bus.start) begin
          // Round 0 consumes K0 unrotated, so K0 is stored already advanced.
          st_q    <= bus.pt ^ bus.key[127:64];
          k0_q    <= rotl_step(bus.key[127:64]);
          k1_q    <= bus.key[63:0];
          round_q <= 4'd1;
        end
      end else begin
        st_q    <= bus.rf_out ^ rk;
        round_q <= round_q + 4'd1;
        if (round_q[0]) k1_q <= rotl_step(k1_q);
        else            k0_q <= rotl_step(k0_q);
        if (final_rnd) begin
          ct_q   <= bus.rf_out ^ rk;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign bus.rf_in      = st_q;
  assign bus.busy       = busy;
  assign bus.last_round = final_rnd;
  assign bus.done       = done_q;
  assign bus.ct         = ct_q;

endmodule

// File: tb/tb_fc_round_engine.sv
// Directed and model-checked bench for fc_round_engine with an identity or
// a real substitution/shift/mix round function in the feedback path.
module tb_fc_round_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   real_rf = 1'b0;
  int   checks = 0;
  int   failures = 0;

  fc_round_engine_if bus ();

  fc_round_engine #(.NROUNDS(10), .ROT(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] sbox(input logic [3:0] x);
    logic [63:0] tab;
    tab = 64'h21748FE3DA09B65C;
    return tab[4*x +: 4];
  endfunction

  function automatic logic [63:0] round_fn(input logic [63:0] s, input logic last);
    logic [63:0] sub, shf, res;
    logic [15:0] col;
    for (int n = 0; n < 16; n++) sub[4*n +: 4] = sbox(s[4*n +: 4]);
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        shf[16*c + 4*r +: 4] = sub[16*((c + r) % 4) + 4*r +: 4];
    res = shf;
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        col = shf[16*c +: 16];
        res[16*c +: 16] = col ^ {col[11:0], col[15:12]} ^ {col[7:0], col[15:8]};
      end
    end
    return res;
  endfunction

  // Golden model: key halves rotated directly by the full amount for round i.
  function automatic logic [63:0] model_ct(input logic [63:0] p, input logic [127:0] k);
    logic [63:0] s, h, r;
    int amt;
    s = p ^ k[127:64];
    for (int i = 1; i <= 10; i++) begin
      h   = (i % 2 == 1) ? k[63:0] : k[127:64];
      amt = (5 * (i / 2)) % 64;
      r   = (amt == 0) ? h : ((h << amt) | (h >> (64 - amt)));
      s   = round_fn(s, i == 10) ^ r ^ 64'(i);
    end
    return s;
  endfunction

  always_comb bus.rf_out = real_rf ? round_fn(bus.rf_in, bus.last_round) : bus.rf_in;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_run(input logic [63:0] p, input logic [127:0] k, input bit keep);
    bus.pt    = p;
    bus.key   = k;
    bus.start = 1'b1;
    tick();
    if (!keep) bus.start = 1'b0;
  endtask

  // Called in the cycle after the accepting edge; n counts edges until done.
  task automatic wait_done(input bit hammer, output int n, output int busy_cnt,
                           output int lr_cnt, output bit lr_prev, output bit ct_stable);
    logic [63:0] ct0;
    ct0 = bus.ct; n = 0; busy_cnt = 0; lr_cnt = 0; lr_prev = 1'b0; ct_stable = 1'b1;
    while (!bus.done && n < 40) begin
      if (bus.busy) busy_cnt++;
      if (bus.last_round) lr_cnt++;
      lr_prev = bus.last_round;
      if (bus.ct !== ct0) ct_stable = 1'b0;
      if (hammer) begin
        bus.start = 1'b1;
        bus.pt    = {$urandom, $urandom};
        bus.key   = {$urandom, $urandom, $urandom, $urandom};
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.ct !== 64'h0) begin failures++; $display("FAIL reset_ct got=%h exp=0", bus.ct); end
    checks++; if (bus.rf_in !== 64'h0) begin failures++; $display("FAIL reset_rf_in got=%h exp=0", bus.rf_in); end
    checks++; if (bus.last_round !== 1'b0) begin failures++; $display("FAIL reset_last_round got=%b exp=0", bus.last_round); end
    #12 rst_n = 1'b1;
    tick();
    $display("reset: busy=%b done=%b ct=%h", bus.busy, bus.done, bus.ct);
  endtask

  task automatic test_identity_zero();
    int n, bc, lc; bit lp, cs;
    begin_run(64'h0, 128'h0, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL id0_busy_after_start got=%b exp=1", bus.busy); end
    wait_done(1'b0, n, bc, lc, lp, cs);
    $display("identity pt=0 key=0: latency=%0d busy_cycles=%0d ct=%h", n, bc, bus.ct);
    checks++; if (n !== 10) begin failures++; $display("FAIL id0_latency got=%0d exp=10", n); end
    checks++; if (bc !== 10) begin failures++; $display("FAIL id0_busy_cycles got=%0d exp=10", bc); end
    checks++; if (bus.ct !== 64'h000000000000000B) begin failures++; $display("FAIL id0_ct got=%h exp=000000000000000b", bus.ct); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL id0_busy_at_done got=%b exp=0", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL id0_done_width got=%b exp=0", bus.done); end
  endtask

  task automatic test_identity_k0();
    int n, bc, lc; bit lp, cs;
    begin_run(64'h0, 128'h0000000000000001_0000000000000000, 1'b0);
    checks++; if (bus.rf_in !== 64'h1) begin failures++; $display("FAIL k0_whitening got=%h exp=1", bus.rf_in); end
    wait_done(1'b0, n, bc, lc, lp, cs);
    $display("identity pt=0 K0=1: latency=%0d ct=%h", n, bus.ct);
    checks++; if (bus.ct !== 64'h000000000210842A) begin failures++; $display("FAIL k0_ct got=%h exp=000000000210842a", bus.ct); end
    checks++; if (lc !== 1 || lp !== 1'b1) begin failures++; $display("FAIL k0_last_round got=%0d/%b exp=1/1", lc, lp); end
  endtask

  task automatic test_start_during_run();
    int n, bc, lc; bit lp, cs;
    begin_run(64'h0, 128'h0, 1'b1);
    wait_done(1'b1, n, bc, lc, lp, cs);
    bus.start = 1'b0;
    $display("start hammered: latency=%0d busy_cycles=%0d ct=%h", n, bc, bus.ct);
    checks++; if (n !== 10) begin failures++; $display("FAIL hammer_latency got=%0d exp=10", n); end
    checks++; if (bc !== 10) begin failures++; $display("FAIL hammer_busy_cycles got=%0d exp=10", bc); end
    checks++; if (bus.ct !== 64'h000000000000000B) begin failures++; $display("FAIL hammer_ct got=%h exp=000000000000000b", bus.ct); end
    tick();
    checks++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL hammer_single_done got=%b/%b exp=0/0", bus.done, bus.busy); end
  endtask

  task automatic test_back_to_back();
    int n, bc, lc; bit lp, cs;
    begin_run(64'h0, 128'h0, 1'b1);
    wait_done(1'b0, n, bc, lc, lp, cs);
    $display("back-to-back run 1: latency=%0d ct=%h", n, bus.ct);
    checks++; if (bus.ct !== 64'h000000000000000B) begin failures++; $display("FAIL b2b_ct1 got=%h exp=000000000000000b", bus.ct); end
    bus.key = 128'h0000000000000001_0000000000000000;
    tick();
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL b2b_accept got=%b exp=1", bus.busy); end
    wait_done(1'b0, n, bc, lc, lp, cs);
    $display("back-to-back run 2: latency=%0d ct=%h", n, bus.ct);
    checks++; if (n !== 10) begin failures++; $display("FAIL b2b_latency2 got=%0d exp=10", n); end
    checks++; if (cs !== 1'b1) begin failures++; $display("FAIL b2b_ct_stable got=%b exp=1", cs); end
    checks++; if (bus.ct !== 64'h000000000210842A) begin failures++; $display("FAIL b2b_ct2 got=%h exp=000000000210842a", bus.ct); end
  endtask

  task automatic test_async_reset();
    int n, bc, lc, dones; bit lp, cs;
    begin_run(64'h0, 128'h0, 1'b0);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    $display("async reset mid-run: busy=%b done=%b ct=%h", bus.busy, bus.done, bus.ct);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.ct !== 64'h0) begin failures++; $display("FAIL arst_ct got=%h exp=0", bus.ct); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", bus.done); end
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (15) begin tick(); if (bus.done) dones++; end
    checks++; if (dones !== 0) begin failures++; $display("FAIL arst_no_done got=%0d exp=0", dones); end
    begin_run(64'h0, 128'h0, 1'b0);
    wait_done(1'b0, n, bc, lc, lp, cs);
    $display("after reset run: latency=%0d ct=%h", n, bus.ct);
    checks++; if (n !== 10 || bus.ct !== 64'h000000000000000B) begin failures++; $display("FAIL arst_fresh got=%0d/%h exp=10/000000000000000b", n, bus.ct); end
  endtask

  task automatic test_real_round();
    int n, bc, lc; bit lp, cs;
    logic [63:0] p, exp_ct;
    logic [127:0] k;
    real_rf = 1'b1;
    for (int t = 0; t < 1000; t++) begin
      p = {$urandom, $urandom};
      k = {$urandom, $urandom, $urandom, $urandom};
      exp_ct = model_ct(p, k);
      begin_run(p, k, 1'b0);
      wait_done(1'b0, n, bc, lc, lp, cs);
      $display("real #%0d pt=%h key=%h ct=%h exp=%h", t, p, k, bus.ct, exp_ct);
      checks++; if (bus.ct !== exp_ct) begin failures++; $display("FAIL real_ct[%0d] got=%h exp=%h", t, bus.ct, exp_ct); end
      checks++; if (lc !== 1 || lp !== 1'b1 || n !== 10) begin failures++; $display("FAIL real_timing[%0d] lr=%0d/%b lat=%0d exp=1/1/10", t, lc, lp, n); end
    end
    real_rf = 1'b0;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.pt    = '0;
    bus.key   = '0;
    test_reset();
    test_identity_zero();
    test_identity_k0();
    test_start_during_run();
    test_back_to_back();
    test_async_reset();
    test_real_round();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/fc_round_engine.md
Name: fc_round_engine

Overview:
Iterative 64-bit encryption round engine for the FUTURE-style cipher datapath. It is the stage directly downstream of the combinational round function (nibble substitution, row shift, and four copies of the 16-bit column-mix block). It holds the cipher state register, sequences NROUNDS rounds, generates round keys, applies AddRoundKey, and provides a start/done handshake.

Parameters:
NROUNDS, 10, number of keyed rounds after the initial whitening (1..15)
ROT, 5, left-rotation step in bits applied to a key half every two rounds

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request to begin encryption; sampled only when busy=0
pt  input  64  plaintext; sampled on the accepting edge
key  input  128  cipher key; sampled on the accepting edge; K0=key[127:64], K1=key[63:0]
rf_in  output  64  current state register, driven to the external round function
rf_out  input  64  combinational round-function result for rf_in
last_round  output  1  high while the final round is being computed; round function omits column mix
busy  output  1  high while an encryption is in progress
done  output  1  one-cycle pulse; ct valid and updated in the same cycle
ct  output  64  ciphertext register; holds until the next completion

Behaviour:
- Reset: clk is the only clock. rst_n is asynchronous and active-low. On reset, state=0, round=0, key register=0, busy=0, done=0, ct=0, last_round=0. Reset mid-operation aborts the run; no done pulse is produced.
- FSM states:
  - IDLE (busy=0).
  - RUN (busy=1).
- IDLE: if start=1 at edge E0:
  - state <= pt ^ rk(0)
  - key register <= key
  - round <= 1
  - go to RUN
- RUN, at each edge:
  - state <= rf_out ^ rk(round)
  - round <= round+1
- At the edge where round==NROUNDS (edge E_NROUNDS):
  - ct <= rf_out ^ rk(NROUNDS)
  - done <= 1
  - busy <= 0
  - go to IDLE
- done is registered and high for exactly one cycle. Latency is NROUNDS cycles from the start-sampling edge to the done-high cycle.
- Round key definition: rk(i) = rotl(H, (ROT*(i>>1)) mod 64) ^ {56'h0, i[7:0]}, where H=K0 for even i and H=K1 for odd i. rk(0)=K0.
- Round key implementation: rotate each key half incrementally. The K0 half rotates after each even round is used, and the K1 half after each odd round. Do not use a full barrel shifter.
- rf_in equals the state register at all times. last_round = busy & (round==NROUNDS).
- start while busy=1 is ignored with no side effects. pt and key may change freely during RUN.
- Back-to-back: in the done cycle busy=0, so start=1 in that cycle is accepted at the next edge.
- ct is unchanged except at completion edges.
- round counter is 4 bits wide. It never wraps during a legal run.

Test Plan:
- Identity stub (rf_out=rf_in), pt=0, key=0, start pulse -> done exactly 10 cycles after the start edge; ct=64'h000000000000000B; busy high for 10 cycles.
- Identity stub, pt=0, key=128'h0000000000000001_0000000000000000 -> ct=64'h000000000210842A.
- Start re-asserted every cycle during RUN -> a single done pulse; ct is the result of the first pt/key only; busy never drops early.
- Start held high through done -> second run accepted in the done cycle; second done 10 cycles later; ct updates only on each done.
- rst_n pulsed low during round 5 -> busy, done and ct go to 0 immediately without waiting for clk; no done follows; a fresh start after release completes normally.
- Real round function (S-layer + shift + 4x column mix, mix skipped when last_round=1), 1000 random pt/key -> ct matches the golden software model. last_round is high exactly one cycle per run, immediately before the done cycle.
